// File: rtl/wm8731_i2c_responder.sv
`timescale 1ns/1ps
// wm8731_i2c_responder
//   I2C write-only target modelling the WM8731 control port. It accepts
//   3-byte writes {DEV_ADDR,0} / {reg[6:0],data[8]} / data[7:0] and updates a
//   ten-entry shadow register file. Register 15 restores all defaults.
//   Contents are read back through rd_addr/rd_data, never over I2C.
//
// Ports
//   iCLK, iRST_N     system clock, asynchronous active-low reset
//   scl_in, sda_in   asynchronous bus lines, oversampled on iCLK
//   sda_oe           1 = pull SDA low (ACK)
//   rd_addr/rd_data  combinational shadow read port (0 beyond R9)
//   wr_valid         one-cycle pulse per committed write (incl. reg 15)
//   wr_addr/wr_data  address/data of the last commit
//   bad_reg          one-cycle pulse for a complete write to an unimplemented reg
//   busy             high between START and STOP
//
// Build option
//   I2C_RESP_GLITCH_FILTER_EN: adds a 3-sample majority filter after the
//   synchronizers (rejects 1-cycle pulses, detection latency 5 iCLK).
module wm8731_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYS_DIV_MIN = 4
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       bad_reg,
  output logic       busy
);

  if (SYS_DIV_MIN < 3) begin : g_div_check
    $error("SYS_DIV_MIN must be at least 3 iCLK per SCL half-period");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_DRAIN
  } state_t;

  localparam logic [8:0] SHADOW_DEF [10] = '{
    9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
    9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
  };

  // Input conditioning. Lines idle high, so reset to 1 to avoid a false edge.
  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  logic [2:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[1:0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[1:0], r_sda_sync[1]};
      r_scl_filt <= (r_scl_hist[0] & r_scl_hist[1]) | (r_scl_hist[0] & r_scl_hist[2]) |
                    (r_scl_hist[1] & r_scl_hist[2]);
      r_sda_filt <= (r_sda_hist[0] & r_sda_hist[1]) | (r_sda_hist[0] & r_sda_hist[2]) |
                    (r_sda_hist[1] & r_sda_hist[2]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  logic r_scl_prev, r_sda_prev;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  // START/STOP need SCL high in both samples, so an SDA change landing in
  // the same sample as an SCL edge is treated as ordinary data.
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shift, r_byte1;
  logic [2:0] r_cnt;
  logic       r_full;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_scl_fall) begin
      unique case (r_state)
        S_ADDR:  if (r_full) w_state_nxt = (r_shift == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_DRAIN;
        S_ACK_A: w_state_nxt = S_BYTE1;
        S_BYTE1: if (r_full) w_state_nxt = S_ACK_1;
        S_ACK_1: w_state_nxt = S_BYTE2;
        S_BYTE2: if (r_full) w_state_nxt = S_ACK_2;
        S_ACK_2: w_state_nxt = S_DRAIN;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  logic       w_sda_oe_nxt, w_commit, w_hit, w_clear, w_bad, w_shift_en;
  logic [6:0] w_reg;
  logic [8:0] w_data;

  always_comb begin
    w_sda_oe_nxt = w_state_nxt inside {S_ACK_A, S_ACK_1, S_ACK_2};
    // Only an SCL fall moves ACK_2 to DRAIN; START/STOP go elsewhere.
    w_commit     = (r_state == S_ACK_2) && (w_state_nxt == S_DRAIN);
    w_reg        = r_byte1[7:1];
    w_data       = {r_byte1[0], r_shift};
    w_hit        = w_commit && (w_reg < 7'd10);
    w_clear      = w_commit && (w_reg == 7'd15);
    w_bad        = w_commit && !(w_reg < 7'd10) && (w_reg != 7'd15);
    w_shift_en   = w_scl_rise && !r_full && (r_state inside {S_ADDR, S_BYTE1, S_BYTE2});
  end

  logic       r_sda_oe, r_wr_valid, r_bad_reg;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_shift    <= '0;
      r_byte1    <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_bad_reg  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_valid <= w_hit | w_clear;
      r_bad_reg  <= w_bad;
      if (w_hit) begin
        r_wr_addr <= w_reg;
        r_wr_data <= w_data;
      end else if (w_clear) begin
        r_wr_addr <= 7'd15;
      end
      // A repeated START inside ADDR keeps the state, so it must restart the count too.
      if (w_start || (r_state != w_state_nxt)) begin
        r_cnt  <= '0;
        r_full <= 1'b0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[6:0], w_sda};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) r_full <= 1'b1;
      end
      if ((r_state == S_BYTE1) && (w_state_nxt == S_ACK_1)) r_byte1 <= r_shift;
    end
  end

  logic [8:0] r_shadow [10];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < 10; i++) r_shadow[i] <= SHADOW_DEF[i];
    end else if (w_clear) begin
      for (int unsigned i = 0; i < 10; i++) r_shadow[i] <= SHADOW_DEF[i];
    end else if (w_hit) begin
      r_shadow[w_reg[3:0]] <= w_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < 4'd10) rd_data = r_shadow[rd_addr];
  end

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign bad_reg  = r_bad_reg;
  assign busy     = (r_state != S_IDLE);

endmodule
